// File: rtl/boot_release_sequencer.sv
// boot_release_sequencer
// Restarts the EEPROM-to-RAM bootstrap copier, waits for it to finish,
// lets the copier's bus drivers settle, then hands the bus to the 65C02
// and releases its reset after a minimum-width reset pulse. A copy that
// never completes parks the block in ERROR with the boot_error LED lit.
// A rising edge on the debounced reboot button re-runs the whole sequence
// from any state.
//
// All outputs come straight from flops. The output flops are loaded from
// the decode of the next state, so they always match the state register
// and no input ever reaches an output combinationally.

module boot_release_sequencer #(
    parameter int unsigned COPY_RESET_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES     = 16,
    parameter int unsigned CPU_RESET_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES    = 40000,
    parameter int unsigned CNT_W             = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       copy_done,
    input  logic       soft_reset_req,
    output logic       copy_reset_n,
    output logic       cpu_be,
    output logic       cpu_rdy,
    output logic       cpu_reset_n,
    output logic       boot_error,
    output logic [2:0] state_o
);

    // Sequencer states; the encoding is visible on state_o for debug.
    typedef enum logic [2:0] {
        RESTART_COPY = 3'd0,
        WAIT_COPY    = 3'd1,
        SETTLE       = 3'd2,
        CPU_RESET    = 3'd3,
        RUN          = 3'd4,
        ERROR        = 3'd5
    } state_t;

    // Counter reload values: a timed state lasting N cycles loads N-1 and
    // leaves on the edge where the counter has reached zero.
    localparam logic [CNT_W-1:0] COPY_LOAD    = CNT_W'(COPY_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPURST_LOAD  = CNT_W'(CPU_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // Output vector layout: {copy_reset_n, cpu_be, cpu_rdy, cpu_reset_n, boot_error}
    localparam logic [4:0] OUT_RESTART = 5'b00000;
    localparam logic [4:0] OUT_WAIT    = 5'b10000;
    localparam logic [4:0] OUT_SETTLE  = 5'b10000;
    localparam logic [4:0] OUT_CPURST  = 5'b11100;
    localparam logic [4:0] OUT_RUN     = 5'b11110;
    localparam logic [4:0] OUT_ERROR   = 5'b10001;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             soft_prev;
    logic             soft_rise;
    logic             cnt_zero;
    logic             done_blanked;

    // Map a state onto the five control pins. Unused codes fall back to
    // the safe RESTART_COPY pattern: CPU held off the bus and in reset.
    function automatic logic [4:0] decode_outputs(input state_t s);
        logic [4:0] v;
        case (s)
            RESTART_COPY: v = OUT_RESTART;
            WAIT_COPY:    v = OUT_WAIT;
            SETTLE:       v = OUT_SETTLE;
            CPU_RESET:    v = OUT_CPURST;
            RUN:          v = OUT_RUN;
            ERROR:        v = OUT_ERROR;
            default:      v = OUT_RESTART;
        endcase
        return v;
    endfunction

    // Button edge and counter qualifiers used by the transition logic.
    always_comb begin
        soft_rise    = soft_reset_req & ~soft_prev;
        cnt_zero     = (cnt == CNT_ZERO);
        // On the first WAIT_COPY cycle copy_done may still be the DONE
        // level left over from the previous boot, so it is not trusted.
        done_blanked = (cnt == TIMEOUT_LOAD);
    end

    // Next-state and counter logic; a button edge overrides everything.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (soft_rise) begin
            state_next = RESTART_COPY;
            cnt_next   = COPY_LOAD;
        end else begin
            case (state)
                RESTART_COPY: begin
                    if (cnt_zero) begin
                        state_next = WAIT_COPY;
                        cnt_next   = TIMEOUT_LOAD;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                WAIT_COPY: begin
                    // A completion seen on the very last timeout cycle
                    // still counts as a good copy.
                    if (copy_done && !done_blanked) begin
                        state_next = SETTLE;
                        cnt_next   = SETTLE_LOAD;
                    end else if (cnt_zero) begin
                        state_next = ERROR;
                        cnt_next   = CNT_ZERO;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                SETTLE: begin
                    // copy_done is deliberately not looked at here.
                    if (cnt_zero) begin
                        state_next = CPU_RESET;
                        cnt_next   = CPURST_LOAD;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                CPU_RESET: begin
                    if (cnt_zero) begin
                        state_next = RUN;
                        cnt_next   = CNT_ZERO;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                RUN: begin
                    state_next = RUN;
                    cnt_next   = cnt;
                end
                ERROR: begin
                    state_next = ERROR;
                    cnt_next   = cnt;
                end
                default: begin
                    // Codes 6 and 7 are not reachable; recover by rebooting.
                    state_next = RESTART_COPY;
                    cnt_next   = COPY_LOAD;
                end
            endcase
        end
    end

    // State, counter, button history and registered control outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= RESTART_COPY;
            cnt          <= COPY_LOAD;
            soft_prev    <= 1'b0;
            copy_reset_n <= OUT_RESTART[4];
            cpu_be       <= OUT_RESTART[3];
            cpu_rdy      <= OUT_RESTART[2];
            cpu_reset_n  <= OUT_RESTART[1];
            boot_error   <= OUT_RESTART[0];
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            soft_prev <= soft_reset_req;
            {copy_reset_n, cpu_be, cpu_rdy, cpu_reset_n, boot_error} <= decode_outputs(state_next);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_boot_release_sequencer.sv
// tb_boot_release_sequencer
// Directed bench for the boot release sequencer. A behavioural model tracks
// which phase the boot should be in and how long it has been there; every
// negedge the DUT pins are compared with the model's phase and the pin table.
// Directed steps add hand-computed cycle counts and literal pin values.

module tb_boot_release_sequencer;

    localparam int COPY    = 4;
    localparam int SETTLE  = 16;
    localparam int CPURST  = 8;
    localparam int TIMEOUT = 40000;

    localparam int S_CRN   = 0;
    localparam int S_BE    = 1;
    localparam int S_RDY   = 2;
    localparam int S_RSTN  = 3;
    localparam int S_ERR   = 4;
    localparam int S_STATE = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       copy_done = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       copy_reset_n;
    logic       cpu_be;
    logic       cpu_rdy;
    logic       cpu_reset_n;
    logic       boot_error;
    logic [2:0] state_o;

    int tests  = 0;
    int failed = 0;
    bit chk    = 1'b0;

    int m_phase = 0;
    int m_time  = 0;
    bit m_prev  = 1'b0;

    boot_release_sequencer #(
        .COPY_RESET_CYCLES(COPY),
        .SETTLE_CYCLES(SETTLE),
        .CPU_RESET_CYCLES(CPURST),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .copy_done(copy_done),
        .soft_reset_req(soft_reset_req),
        .copy_reset_n(copy_reset_n),
        .cpu_be(cpu_be),
        .cpu_rdy(cpu_rdy),
        .cpu_reset_n(cpu_reset_n),
        .boot_error(boot_error),
        .state_o(state_o)
    );

    initial begin
        forever #5 clock = ~clock;
    end

    // Pin table per phase: {copy_reset_n, cpu_be, cpu_rdy, cpu_reset_n, boot_error}
    function automatic logic [4:0] exp_out(input int ph);
        case (ph)
            0:       return 5'b00000;
            1, 2:    return 5'b10000;
            3:       return 5'b11100;
            4:       return 5'b11110;
            5:       return 5'b10001;
            default: return 5'b00000;
        endcase
    endfunction

    // Has the phase run its course, given time already spent in it?
    function automatic bit phase_exit(input int ph, input int t, input logic done);
        case (ph)
            0:       return t == COPY - 1;
            1:       return (t >= 1 && done === 1'b1) || t == TIMEOUT - 1;
            2:       return t == SETTLE - 1;
            3:       return t == CPURST - 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int phase_after(input int ph, input int t, input logic done);
        if (ph == 1) return (t >= 1 && done === 1'b1) ? 2 : 5;
        return ph + 1;
    endfunction

    // Reference model: phase number plus cycles elapsed in that phase.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_time  <= 0;
            m_prev  <= 1'b0;
        end else begin
            m_prev <= soft_reset_req;
            if (soft_reset_req && !m_prev) begin
                m_phase <= 0;
                m_time  <= 0;
            end else if (phase_exit(m_phase, m_time, copy_done)) begin
                m_phase <= phase_after(m_phase, m_time, copy_done);
                m_time  <= 0;
            end else begin
                m_time <= m_time + 1;
            end
        end
    end

    function automatic int probe(input int sel);
        case (sel)
            S_CRN:   return int'(copy_reset_n);
            S_BE:    return int'(cpu_be);
            S_RDY:   return int'(cpu_rdy);
            S_RSTN:  return int'(cpu_reset_n);
            S_ERR:   return int'(boot_error);
            default: return int'(state_o);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next negedge and compare every pin with the model.
    task automatic tick();
        logic [4:0] got;
        @(negedge clock);
        if (chk) begin
            got = {copy_reset_n, cpu_be, cpu_rdy, cpu_reset_n, boot_error};
            tests++;
            if (int'(state_o) !== m_phase || got !== exp_out(m_phase)) begin
                failed++;
                $display("FAIL cycle_compare t=%0t: state %0d pins %b, expected state %0d pins %b",
                         $time, state_o, got, m_phase, exp_out(m_phase));
            end
        end
    endtask

    // Count negedges until a pin reaches a value; -1 if the bound expires.
    task automatic wait_val(input int sel, input int val, input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (probe(sel) != val && n < bound);
        if (probe(sel) != val) n = -1;
    endtask

    task automatic pulse_soft();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
    endtask

    int n;

    initial begin
        // Reset state
        repeat (3) tick();
        chk = 1'b1;
        check("reset_state", int'(state_o), 0);
        check("reset_copy_reset_n", int'(copy_reset_n), 0);
        check("reset_cpu_reset_n", int'(cpu_reset_n), 0);

        // Nominal boot
        reset = 1'b0;
        wait_val(S_CRN, 1, 20, n);
        check("nominal_copy_reset_len", n, 4);
        check("nominal_wait_state", int'(state_o), 1);
        repeat (2000) tick();
        copy_done = 1'b1;
        wait_val(S_STATE, 2, 10, n);
        check("nominal_done_to_settle", n, 1);
        wait_val(S_BE, 1, 100, n);
        check("nominal_settle_len", n, 16);
        check("nominal_rdy", int'(cpu_rdy), 1);
        check("nominal_cpu_reset_state", int'(state_o), 3);
        wait_val(S_RSTN, 1, 100, n);
        check("nominal_cpu_reset_len", n, 8);
        check("nominal_run_state", int'(state_o), 4);

        // Soft reboot from RUN, button held for 100 cycles
        soft_reset_req = 1'b1;
        copy_done = 1'b0;
        wait_val(S_STATE, 0, 5, n);
        check("soft_restart_next_edge", n, 1);
        check("soft_cpu_reset_n", int'(cpu_reset_n), 0);
        check("soft_cpu_be", int'(cpu_be), 0);
        wait_val(S_CRN, 1, 10, n);
        check("soft_copy_reset_len", n, 4);
        repeat (95) tick();
        check("soft_held_single_restart", int'(state_o), 1);
        soft_reset_req = 1'b0;
        copy_done = 1'b1;
        wait_val(S_STATE, 4, 100, n);
        check("soft_done_to_run", n, 25);

        // Stale done held high through a reboot
        pulse_soft();
        check("stale_restart", int'(state_o), 0);
        wait_val(S_STATE, 1, 10, n);
        check("stale_copy_reset_len", n, 4);
        wait_val(S_STATE, 2, 10, n);
        check("stale_wait_len", n, 2);
        wait_val(S_STATE, 4, 100, n);
        check("stale_settle_to_run", n, 24);

        // Copy timeout
        copy_done = 1'b0;
        pulse_soft();
        wait_val(S_STATE, 1, 10, n);
        check("timeout_copy_reset_len", n, 4);
        wait_val(S_STATE, 5, TIMEOUT + 100, n);
        check("timeout_wait_len", n, 40000);
        check("timeout_boot_error", int'(boot_error), 1);
        check("timeout_cpu_be", int'(cpu_be), 0);
        check("timeout_cpu_reset_n", int'(cpu_reset_n), 0);
        repeat (10) tick();
        check("timeout_error_holds", int'(state_o), 5);
        pulse_soft();
        check("timeout_recover_state", int'(state_o), 0);
        check("timeout_recover_error", int'(boot_error), 0);

        // Async reset in cycle 5 of SETTLE
        copy_done = 1'b1;
        wait_val(S_STATE, 2, 20, n);
        check("areset_reach_settle", n, 6);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        check("areset_state_immediate", int'(state_o), 0);
        check("areset_copy_reset_n_immediate", int'(copy_reset_n), 0);
        tick();
        tick();
        reset = 1'b0;
        wait_val(S_STATE, 4, 100, n);
        check("areset_full_sequence_len", n, 30);
        check("areset_cpu_reset_n", int'(cpu_reset_n), 1);

        // copy_done arrives on the last timeout cycle; then a button edge
        // on the last CPU_RESET cycle
        copy_done = 1'b0;
        pulse_soft();
        wait_val(S_STATE, 1, 10, n);
        check("boundary_copy_reset_len", n, 4);
        repeat (TIMEOUT - 1) tick();
        copy_done = 1'b1;
        tick();
        check("boundary_settle_wins", int'(state_o), 2);
        check("boundary_no_error", int'(boot_error), 0);
        wait_val(S_STATE, 3, 50, n);
        check("boundary_settle_len", n, 16);
        repeat (7) tick();
        soft_reset_req = 1'b1;
        tick();
        check("preempt_run_state", int'(state_o), 0);
        check("preempt_cpu_reset_n", int'(cpu_reset_n), 0);
        soft_reset_req = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/boot_release_sequencer.md
Name: boot_release_sequencer

Overview:
- Sits directly downstream of the EEPROM-to-RAM bootstrap copier.
- Restarts the copier, waits for it to report completion, then hands the bus to the 65C02 and releases CPU reset:
  - first waits a settle window so the copier has tri-stated address and control;
  - then asserts bus enable and holds CPU reset for a minimum pulse.
- Flags a boot error if the copy never completes. Supports a button-driven soft reboot that re-runs the full copy.

Parameters:
COPY_RESET_CYCLES, 4, cycles copy_reset_n is held low (copier samples reset synchronously)
SETTLE_CYCLES, 16, cycles between copy_done sampled and cpu_be asserted
CPU_RESET_CYCLES, 8, cycles cpu_reset_n is held low with bus enabled (65C02 needs >=2)
TIMEOUT_CYCLES, 40000, max cycles in WAIT_COPY before ERROR (8 KB copy takes ~8193)
CNT_W, 16, shared down-counter width; every *_CYCLES value must be in 1..2^CNT_W-1

Ports:
clock  input  1  system clock (1 MHz nominal)
reset  input  1  asynchronous, active-high; forces RESTART_COPY immediately
copy_done  input  1  high while copier is in DONE (bus released by copier)
soft_reset_req  input  1  debounced reboot button, synchronous to clock, level
copy_reset_n  output  1  drives copier reset_n; low = restart copy
cpu_be  output  1  65C02 BE; low = CPU tri-states bus
cpu_rdy  output  1  65C02 RDY
cpu_reset_n  output  1  65C02 RESB
boot_error  output  1  copy timeout indicator (LED)
state_o  output  3  current state code, for debug

Behaviour:
- All outputs are registered and decoded from the state register. There is no combinational path from any input to any output.
- State codes:
  - RESTART_COPY=0, WAIT_COPY=1, SETTLE=2, CPU_RESET=3, RUN=4, ERROR=5.
  - Codes 6 and 7 go to RESTART_COPY on the next edge.
- Output values per state, in the order copy_reset_n / cpu_be / cpu_rdy / cpu_reset_n / boot_error:
  - RESTART_COPY: 0/0/0/0/0
  - WAIT_COPY: 1/0/0/0/0
  - SETTLE: 1/0/0/0/0
  - CPU_RESET: 1/1/1/0/0
  - RUN: 1/1/1/1/0
  - ERROR: 1/0/0/0/1
- Reset (async, reset=1):
  - state=RESTART_COPY, cnt=COPY_RESET_CYCLES-1, soft_prev=0.
  - Outputs are at the RESTART_COPY values while reset is high.
  - Applying reset in any state, mid-copy included, aborts the sequence.
- Counter rule:
  - On entry to a timed state, cnt loads that state's parameter minus 1. It decrements every cycle and the state exits on the edge where cnt==0.
  - A timed state therefore lasts exactly N cycles.
- RESTART_COPY: lasts COPY_RESET_CYCLES, then goes to WAIT_COPY with cnt=TIMEOUT_CYCLES-1.
- WAIT_COPY:
  - copy_done is ignored on the first cycle (cnt==TIMEOUT_CYCLES-1). This blanks the stale DONE left from a previous boot.
  - Otherwise, copy_done=1 goes to SETTLE (cnt=SETTLE_CYCLES-1).
  - If cnt==0 and copy_done=0, go to ERROR.
  - If copy_done=1 and cnt==0 occur together, SETTLE wins.
- SETTLE: lasts SETTLE_CYCLES, then goes to CPU_RESET (cnt=CPU_RESET_CYCLES-1). copy_done falling during SETTLE is ignored.
- CPU_RESET: lasts CPU_RESET_CYCLES, then goes to RUN.
- RUN and ERROR: terminal until a soft reboot or reset.
- Soft reboot:
  - soft_prev registers soft_reset_req every cycle.
  - A rising edge (soft_reset_req=1, soft_prev=0) in any state goes to RESTART_COPY with cnt=COPY_RESET_CYCLES-1 on that edge. This takes priority over all other transitions.
  - A held-high level causes no further restarts.
  - An edge while already in RESTART_COPY reloads the counter, which extends the pulse.
- Latency from reset deassert to cpu_reset_n=1 is COPY_RESET_CYCLES + D + SETTLE_CYCLES + CPU_RESET_CYCLES, where D is the number of cycles spent in WAIT_COPY (D>=2).

Test Plan:
- Reset then nominal boot, defaults:
  - copy_reset_n rises 4 cycles after reset falls.
  - copy_done rises 8194 cycles later.
  - cpu_be/cpu_rdy rise exactly 16 cycles after the edge sampling copy_done.
  - cpu_reset_n rises 8 cycles after that.
  - state_o sequence 0,1,2,3,4.
- Stale done: copy_done held high throughout boot.
  - WAIT_COPY lasts exactly 2 cycles (first cycle blanked).
  - SETTLE is then entered.
- Timeout: copy_done never rises.
  - ERROR is entered exactly 40000 cycles after entering WAIT_COPY; boot_error=1, cpu_be=0, cpu_reset_n=0.
  - A later soft_reset_req pulse returns to state 0 and clears boot_error.
- Soft reboot from RUN: soft_reset_req rises and is held 100 cycles.
  - Next edge: state_o=0, cpu_reset_n=0, cpu_be=0, copy_reset_n=0 for 4 cycles.
  - Only one restart occurs despite the held level.
- Async reset mid-SETTLE (cycle 5 of 16): outputs switch to the RESTART_COPY values without waiting for a clock edge, and the full sequence repeats.
- Boundary: copy_done rises on the same edge cnt reaches 0 in WAIT_COPY.
  - SETTLE is entered, not ERROR.
  - An edge on soft_reset_req during CPU_RESET preempts the transition to RUN.
